// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_pkg
//  Description : Shared types and defaults for the FIR tap sequencer:
//                sequencer state encoding, default geometry and the
//                accumulator width derivation.
//  Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

  localparam int C_DEF_TAPS = 4;
  localparam int C_DEF_DW   = 8;
  localparam int C_DEF_CW   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fir_state_t;

  // Full product width plus one growth bit per doubling of the tap count,
  // so the sum of all taps can never overflow.
  function automatic int acc_width(input int dw, input int cw, input int taps);
    return dw + cw + $clog2(taps);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_tap_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fir_tap_sequencer_if
//  Description : Bundle of the sequencer's coefficient port, sample stream,
//                MAC strobes and result stream. The slave modport is the
//                sequencer's view, the master modport the surrounding logic.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fir_tap_sequencer_if import fir_pkg::*; #(
  parameter int DW    = C_DEF_DW,
  parameter int CW    = C_DEF_CW,
  parameter int IDX_W = $clog2(C_DEF_TAPS),
  parameter int ACCW  = acc_width(C_DEF_DW, C_DEF_CW, C_DEF_TAPS)
) ();

  logic                    cfg_we;
  logic [IDX_W-1:0]        cfg_idx;
  logic signed [CW-1:0]    cfg_data;
  logic                    cfg_ack;

  logic                    s_valid;
  logic signed [DW-1:0]    s_data;
  logic                    s_ready;

  logic signed [DW-1:0]    tap_sample;
  logic signed [CW-1:0]    tap_coef;
  logic                    mac_en;
  logic                    mac_clr;
  logic signed [ACCW-1:0]  acc_in;

  logic                    m_valid;
  logic signed [ACCW-1:0]  m_data;
  logic                    m_ready;

  modport slave (
    input  cfg_we, cfg_idx, cfg_data,
    output cfg_ack,
    input  s_valid, s_data,
    output s_ready,
    output tap_sample, tap_coef, mac_en, mac_clr,
    input  acc_in,
    output m_valid, m_data,
    input  m_ready
  );

  modport master (
    output cfg_we, cfg_idx, cfg_data,
    input  cfg_ack,
    output s_valid, s_data,
    input  s_ready,
    input  tap_sample, tap_coef, mac_en, mac_clr,
    output acc_in,
    input  m_valid, m_data,
    output m_ready
  );

endinterface
`default_nettype wire

// File: rtl/fir_tap_store.sv
`default_nettype none
// ============================================================================
//  Module      : fir_tap_store
//  Description : Sample delay line and coefficient register file with a
//                single tap-indexed read port. Entry 0 holds the newest
//                sample; a shift strobe moves every entry one place older.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_tap_store import fir_pkg::*; #(
  parameter int TAPS  = C_DEF_TAPS,
  parameter int DW    = C_DEF_DW,
  parameter int CW    = C_DEF_CW,
  parameter int IDX_W = $clog2(TAPS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   shift_en,
  input  logic signed [DW-1:0]   shift_data,
  input  logic                   coef_we,
  input  logic [IDX_W-1:0]       coef_idx,
  input  logic signed [CW-1:0]   coef_data,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic signed [DW-1:0]   rd_sample,
  output logic signed [CW-1:0]   rd_coef
);

  logic signed [DW-1:0] w_dline [TAPS];
  logic signed [CW-1:0] w_coef  [TAPS];

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    logic signed [DW-1:0] r_d;
    logic signed [CW-1:0] r_c;

    if (k == 0) begin : g_head
      // Newest sample enters the head of the delay line
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_d <= '0;
        else if (shift_en) r_d <= shift_data;
      end
    end else begin : g_body
      // Older entries take their younger neighbour's value
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_d <= '0;
        else if (shift_en) r_d <= w_dline[k-1];
      end
    end

    // Coefficient k loads only when addressed; out-of-range indices match no entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                  r_c <= '0;
      else if (coef_we && (coef_idx == IDX_W'(k))) r_c <= coef_data;
    end

    assign w_dline[k] = r_d;
    assign w_coef[k]  = r_c;
  end

  assign rd_sample = w_dline[rd_idx];
  assign rd_coef   = w_coef[rd_idx];

endmodule
`default_nettype wire

// File: rtl/fir_tap_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fir_tap_sequencer
//  Description : Time-multiplexes one external 1-cycle registered MAC over
//                all FIR taps. Accepts a sample, runs TAPS accumulate cycles,
//                waits one drain cycle for the last product, then holds the
//                result on a valid/ready output until taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_tap_sequencer import fir_pkg::*; #(
  parameter int TAPS  = C_DEF_TAPS,
  parameter int DW    = C_DEF_DW,
  parameter int CW    = C_DEF_CW,
  parameter int IDX_W = $clog2(TAPS),
  parameter int ACCW  = acc_width(DW, CW, TAPS)
) (
  input  logic                clk,
  input  logic                rst_n,
  fir_tap_sequencer_if.slave  bus
);

  localparam logic [IDX_W-1:0] C_LAST = IDX_W'(TAPS - 1);

  fir_state_t              r_state;
  logic [IDX_W-1:0]        r_cnt;
  logic                    r_mac_en;
  logic                    r_mac_clr;
  logic                    r_s_ready;
  logic                    r_m_valid;
  logic signed [ACCW-1:0]  r_m_data;
  logic                    r_cfg_ack;

  logic                    w_accept;
  logic                    w_cfg_wr;
  logic signed [DW-1:0]    w_tap_sample;
  logic signed [CW-1:0]    w_tap_coef;

  // s_ready is only ever high in IDLE, so it alone qualifies the accept
  assign w_accept = bus.s_valid & r_s_ready;
  // Coefficients may only change while no sample is in flight
  assign w_cfg_wr = bus.cfg_we & (r_state == IDLE);

  fir_tap_store #(
    .TAPS  (TAPS),
    .DW    (DW),
    .CW    (CW),
    .IDX_W (IDX_W)
  ) u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift_en   (w_accept),
    .shift_data (bus.s_data),
    .coef_we    (w_cfg_wr),
    .coef_idx   (bus.cfg_idx),
    .coef_data  (bus.cfg_data),
    .rd_idx     (r_cnt),
    .rd_sample  (w_tap_sample),
    .rd_coef    (w_tap_coef)
  );

  // Sequencer FSM: sample intake, tap counting, MAC strobes and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_mac_en  <= 1'b0;
      r_mac_clr <= 1'b0;
      r_s_ready <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state   <= RUN;
            r_cnt     <= '0;
            r_mac_en  <= 1'b1;
            r_mac_clr <= 1'b1;
            r_s_ready <= 1'b0;
          end else begin
            r_s_ready <= 1'b1;
          end
        end
        RUN: begin
          // Only the first tap loads the MAC; the rest accumulate
          r_mac_clr <= 1'b0;
          if (r_cnt == C_LAST) begin
            r_state  <= DRAIN;
            r_mac_en <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DRAIN: begin
          // Last product has landed in the MAC register by this edge
          r_m_data  <= bus.acc_in;
          r_m_valid <= 1'b1;
          r_state   <= HOLD;
        end
        HOLD: begin
          if (bus.m_ready) begin
            r_m_valid <= 1'b0;
            r_s_ready <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mac_en  <= 1'b0;
          r_mac_clr <= 1'b0;
          r_m_valid <= 1'b0;
          r_s_ready <= 1'b0;
        end
      endcase
    end
  end

  // One-cycle acknowledge for every write taken in IDLE, even to an unused index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cfg_ack <= 1'b0;
    else        r_cfg_ack <= w_cfg_wr;
  end

  assign bus.cfg_ack    = r_cfg_ack;
  assign bus.s_ready    = r_s_ready;
  assign bus.tap_sample = w_tap_sample;
  assign bus.tap_coef   = w_tap_coef;
  assign bus.mac_en     = r_mac_en;
  assign bus.mac_clr    = r_mac_clr;
  assign bus.m_valid    = r_m_valid;
  assign bus.m_data     = r_m_data;

endmodule
`default_nettype wire

// File: tb/tb_fir_tap_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_tap_sequencer
//  Description : Self-checking bench for fir_tap_sequencer with a registered
//                MAC model and an arithmetic reference of the filter sum.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_tap_sequencer;

  localparam int TAPS  = 4;
  localparam int DW    = 8;
  localparam int CW    = 8;
  localparam int IDX_W = 2;
  localparam int ACCW  = 18;
  localparam int LAT   = TAPS + 1;
  localparam int PER   = TAPS + 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fir_tap_sequencer_if #(.DW(DW), .CW(CW), .IDX_W(IDX_W), .ACCW(ACCW)) bus ();

  fir_tap_sequencer #(.TAPS(TAPS), .DW(DW), .CW(CW), .IDX_W(IDX_W), .ACCW(ACCW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Registered MAC: the product strobed with mac_en shows up after the edge
  logic signed [ACCW-1:0]  mac_acc;
  logic signed [DW+CW-1:0] mac_prod;
  assign mac_prod = bus.tap_sample * bus.tap_coef;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          mac_acc <= '0;
    else if (bus.mac_en) mac_acc <= (bus.mac_clr ? '0 : mac_acc) + ACCW'(mac_prod);
  end
  assign bus.acc_in = mac_acc;

  // Reference: the filter is just sum(c[k]*d[k]) over a shifting sample history
  int ref_d [TAPS];
  int ref_c [TAPS];
  int n_checks = 0;
  int n_errors = 0;

  function automatic int ref_result();
    int s = 0;
    for (int k = 0; k < TAPS; k++) s += ref_c[k] * ref_d[k];
    return s;
  endfunction

  function automatic void ref_shift(input int x);
    for (int k = TAPS - 1; k > 0; k--) ref_d[k] = ref_d[k-1];
    ref_d[0] = x;
  endfunction

  function automatic void ref_clear();
    for (int k = 0; k < TAPS; k++) begin ref_d[k] = 0; ref_c[k] = 0; end
  endfunction

  function automatic int rnd8();
    return int'($urandom_range(255)) - 128;
  endfunction

  task automatic idle_inputs();
    bus.s_valid = 1'b0; bus.s_data = '0;
    bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_data = '0;
    bus.m_ready = 1'b1;
  endtask

  task automatic release_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0; ref_clear();
    repeat (3) @(posedge clk);
    release_reset();
  endtask

  // Coefficient write, only called while the sequencer is idle
  task automatic wcoef(input int idx, input int val, output bit ack);
    bus.cfg_we = 1'b1; bus.cfg_idx = IDX_W'(idx); bus.cfg_data = CW'(val);
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    ack = bus.cfg_ack;
    ref_c[idx] = val;
  endtask

  // Offer a sample, wait for acceptance and then for m_valid (bounded)
  task automatic push(input int x, output int lat, output int res, output bit ok);
    int n = 0;
    ok = 1'b1; lat = 0; res = 0;
    bus.s_valid = 1'b1; bus.s_data = DW'(x);
    while (!bus.s_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!bus.s_ready) begin ok = 1'b0; bus.s_valid = 1'b0; return; end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    ref_shift(x);
    while (!bus.m_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!bus.m_valid) ok = 1'b0;
    res = int'(bus.m_data);
  endtask

  task automatic pop();
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int lat, res; bit ok, ack;
    idle_inputs();
    #2 rst_n = 1'b0;
    ref_clear();
    repeat (2) @(posedge clk); #1;
    n_checks++; if (bus.s_ready !== 1'b0) begin n_errors++; $display("FAIL rst_s_ready: got %b want 0", bus.s_ready); end
    n_checks++; if (bus.m_valid !== 1'b0) begin n_errors++; $display("FAIL rst_m_valid: got %b want 0", bus.m_valid); end
    n_checks++; if ({bus.mac_en, bus.mac_clr, bus.cfg_ack} !== 3'b000) begin n_errors++; $display("FAIL rst_strobes: got %b want 000", {bus.mac_en, bus.mac_clr, bus.cfg_ack}); end
    n_checks++; if (bus.m_data !== '0) begin n_errors++; $display("FAIL rst_m_data: got %0d want 0", bus.m_data); end
    release_reset();
    n_checks++; if (bus.s_ready !== 1'b1) begin n_errors++; $display("FAIL post_rst_s_ready: got %b want 1", bus.s_ready); end

    // Reset in the middle of a RUN
    wcoef(0, 7, ack); wcoef(1, -3, ack);
    bus.s_valid = 1'b1; bus.s_data = DW'(5);
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    n_checks++; if (bus.mac_en !== 1'b1) begin n_errors++; $display("FAIL run_started: mac_en got %b want 1", bus.mac_en); end
    @(posedge clk); #1;
    rst_n = 1'b0; ref_clear();
    #1;
    n_checks++; if ({bus.mac_en, bus.m_valid, bus.s_ready} !== 3'b000) begin n_errors++; $display("FAIL midrun_rst: en/valid/ready got %b want 000", {bus.mac_en, bus.m_valid, bus.s_ready}); end
    release_reset();

    // Reset while a result is held
    wcoef(0, 3, ack);
    bus.m_ready = 1'b0;
    push(7, lat, res, ok);
    n_checks++; if (!ok || res !== ref_result()) begin n_errors++; $display("FAIL hold_result: ok=%b got %0d want %0d", ok, res, ref_result()); end
    rst_n = 1'b0; ref_clear();
    #1;
    n_checks++; if (bus.m_valid !== 1'b0 || bus.m_data !== '0) begin n_errors++; $display("FAIL hold_rst: m_valid=%b m_data=%0d want 0/0", bus.m_valid, bus.m_data); end
    bus.m_ready = 1'b1;
    release_reset();

    // Coefficients were cleared: any sample now filters to zero
    push(rnd8() | 1, lat, res, ok);
    n_checks++; if (!ok || res !== ref_result() || res !== 0) begin n_errors++; $display("FAIL zero_coef: ok=%b got %0d want 0", ok, res); end
    n_checks++; if (lat !== LAT) begin n_errors++; $display("FAIL zero_coef_latency: got %0d want %0d", lat, LAT); end
    pop();
  endtask

  task automatic test_impulse();
    int lat, res, acks; bit ok, ack;
    int samples [TAPS];
    apply_reset();
    acks = 0;
    for (int k = 0; k < TAPS; k++) begin wcoef(k, k + 1, ack); acks += int'(ack); end
    n_checks++; if (acks !== TAPS) begin n_errors++; $display("FAIL impulse_acks: got %0d want %0d", acks, TAPS); end
    samples[0] = 1;
    for (int k = 1; k < TAPS; k++) samples[k] = 0;
    for (int i = 0; i < TAPS; i++) begin
      push(samples[i], lat, res, ok);
      n_checks++; if (!ok || res !== ref_result()) begin n_errors++; $display("FAIL impulse_%0d: ok=%b got %0d want %0d", i, ok, res, ref_result()); end
      n_checks++; if (lat !== LAT) begin n_errors++; $display("FAIL impulse_latency_%0d: got %0d want %0d", i, lat, LAT); end
      pop();
    end
  endtask

  task automatic test_extremes();
    int lat, res; bit ok, ack;
    apply_reset();
    for (int k = 0; k < TAPS; k++) wcoef(k, -128, ack);
    for (int i = 0; i < TAPS; i++) begin
      push(-128, lat, res, ok);
      n_checks++; if (!ok || res !== ref_result()) begin n_errors++; $display("FAIL extreme_neg_%0d: ok=%b got %0d want %0d", i, ok, res, ref_result()); end
      pop();
    end
    wcoef(0, -128, ack);
    for (int k = 1; k < TAPS; k++) wcoef(k, 0, ack);
    push(127, lat, res, ok);
    n_checks++; if (!ok || res !== ref_result()) begin n_errors++; $display("FAIL extreme_pos: ok=%b got %0d want %0d", ok, res, ref_result()); end
    pop();
  endtask

  task automatic test_backpressure();
    int lat, res, want, y, n; bit ok, ack;
    apply_reset();
    for (int k = 0; k < TAPS; k++) wcoef(k, rnd8(), ack);
    bus.m_ready = 1'b0;
    push(rnd8(), lat, res, ok);
    want = ref_result();
    n_checks++; if (!ok || res !== want) begin n_errors++; $display("FAIL bp_result: ok=%b got %0d want %0d", ok, res, want); end
    y = rnd8();
    bus.s_valid = 1'b1; bus.s_data = DW'(y);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.m_valid !== 1'b1 || int'(bus.m_data) !== want || bus.s_ready !== 1'b0 || bus.mac_en !== 1'b0) begin
        n_errors++;
        $display("FAIL bp_hold_%0d: valid=%b data=%0d ready=%b mac_en=%b want 1/%0d/0/0", c, bus.m_valid, bus.m_data, bus.s_ready, bus.mac_en, want);
      end
    end
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1 || bus.mac_en !== 1'b0) begin n_errors++; $display("FAIL bp_release: valid=%b ready=%b mac_en=%b want 0/1/0", bus.m_valid, bus.s_ready, bus.mac_en); end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    ref_shift(y);
    n_checks++; if (bus.mac_en !== 1'b1 || bus.s_ready !== 1'b0) begin n_errors++; $display("FAIL bp_accept: mac_en=%b ready=%b want 1/0", bus.mac_en, bus.s_ready); end
    n = 0;
    while (!bus.m_valid && n < 50) begin @(posedge clk); #1; n++; end
    n_checks++; if (bus.m_valid !== 1'b1 || int'(bus.m_data) !== ref_result()) begin n_errors++; $display("FAIL bp_held_sample: valid=%b got %0d want %0d", bus.m_valid, bus.m_data, ref_result()); end
    pop();
  endtask

  task automatic test_config_gating();
    int lat, res, n; bit ok, ack, seen_ack;
    apply_reset();
    for (int k = 0; k < TAPS; k++) wcoef(k, rnd8(), ack);
    bus.s_valid = 1'b1; bus.s_data = DW'(9);
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    ref_shift(9);
    bus.cfg_we = 1'b1; bus.cfg_idx = '0; bus.cfg_data = CW'(99);
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    seen_ack = bus.cfg_ack;
    n = 0;
    while (!bus.m_valid && n < 50) begin @(posedge clk); #1; n++; seen_ack |= bus.cfg_ack; end
    n_checks++; if (seen_ack !== 1'b0) begin n_errors++; $display("FAIL run_write_ack: got %b want 0", seen_ack); end
    n_checks++; if (bus.m_valid !== 1'b1 || int'(bus.m_data) !== ref_result()) begin n_errors++; $display("FAIL run_write_result: valid=%b got %0d want %0d", bus.m_valid, bus.m_data, ref_result()); end
    pop();
    push(rnd8(), lat, res, ok);
    n_checks++; if (!ok || res !== ref_result()) begin n_errors++; $display("FAIL run_write_next: ok=%b got %0d want %0d", ok, res, ref_result()); end
    pop();

    // Write and sample in the same IDLE cycle: the new coefficient applies
    apply_reset();
    bus.cfg_we = 1'b1; bus.cfg_idx = '0; bus.cfg_data = CW'(5);
    bus.s_valid = 1'b1; bus.s_data = DW'(1);
    @(posedge clk); #1;
    bus.cfg_we = 1'b0; bus.s_valid = 1'b0;
    ref_c[0] = 5; ref_shift(1);
    n_checks++; if (bus.cfg_ack !== 1'b1 || bus.mac_en !== 1'b1) begin n_errors++; $display("FAIL same_cycle_start: ack=%b mac_en=%b want 1/1", bus.cfg_ack, bus.mac_en); end
    n = 0;
    while (!bus.m_valid && n < 50) begin @(posedge clk); #1; n++; end
    n_checks++; if (bus.m_valid !== 1'b1 || int'(bus.m_data) !== ref_result()) begin n_errors++; $display("FAIL same_cycle_result: valid=%b got %0d want %0d", bus.m_valid, bus.m_data, ref_result()); end
    pop();
  endtask

  task automatic test_back_to_back();
    int cyc, last; bit got, ack;
    int vals [4];
    apply_reset();
    for (int k = 0; k < TAPS; k++) wcoef(k, rnd8(), ack);
    for (int i = 0; i < 4; i++) vals[i] = rnd8();
    bus.m_ready = 1'b1;
    bus.s_data = DW'(vals[0]); bus.s_valid = 1'b1;
    cyc = 0; last = 0;
    for (int i = 0; i < 4; i++) begin
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin @(posedge clk); #1; cyc++; if (bus.mac_clr) got = 1'b1; end
      n_checks++; if (!got) begin n_errors++; $display("FAIL b2b_accept_%0d: timed out", i); end
      ref_shift(vals[i]);
      if (i < 3) bus.s_data = DW'(vals[i+1]);
      else       bus.s_valid = 1'b0;
      if (i > 0) begin
        n_checks++; if (cyc - last !== PER) begin n_errors++; $display("FAIL b2b_period_%0d: got %0d want %0d", i, cyc - last, PER); end
      end
      last = cyc;
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin @(posedge clk); #1; cyc++; if (bus.m_valid) got = 1'b1; end
      n_checks++; if (!got || int'(bus.m_data) !== ref_result()) begin n_errors++; $display("FAIL b2b_result_%0d: valid=%b got %0d want %0d", i, got, bus.m_data, ref_result()); end
    end
    pop();
  endtask

  task automatic test_random();
    int lat, res, hold; bit ok, ack;
    apply_reset();
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(1) == 1) begin
        wcoef(int'($urandom_range(TAPS - 1)), rnd8(), ack);
        n_checks++; if (ack !== 1'b1) begin n_errors++; $display("FAIL rand_ack_%0d: got %b want 1", i, ack); end
      end
      hold = int'($urandom_range(3));
      bus.m_ready = (hold == 0);
      push(rnd8(), lat, res, ok);
      n_checks++; if (!ok || res !== ref_result() || lat !== LAT) begin n_errors++; $display("FAIL rand_%0d: ok=%b got %0d want %0d lat %0d want %0d", i, ok, res, ref_result(), lat, LAT); end
      if (hold > 0) begin
        repeat (hold) begin @(posedge clk); #1; end
        n_checks++; if (bus.m_valid !== 1'b1 || int'(bus.m_data) !== res) begin n_errors++; $display("FAIL rand_hold_%0d: valid=%b got %0d want %0d", i, bus.m_valid, bus.m_data, res); end
      end
      pop();
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_impulse();
    test_extremes();
    test_backpressure();
    test_config_gating();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
